// File: rtl/amp_ph_freq_averager_if.sv
// Detector-sample input and block-result output bundle for amp_ph_freq_averager.
// The slave modport is the averager itself; the master side feeds samples and consumes results.
interface amp_ph_freq_averager_if #(
  parameter int FULL_SIZE = 20
) ();
  logic                        in_amp_unused_guard;
  logic        [FULL_SIZE-1:0] in_amp;
  logic signed [FULL_SIZE-1:0] in_ph;
  logic                        in_valid;
  logic                        clear;
  logic        [FULL_SIZE-1:0] out_amp;
  logic signed [FULL_SIZE-1:0] out_dph;
  logic signed [FULL_SIZE-1:0] out_ph;
  logic                        out_valid;
  logic                        out_ready;
  logic                        overrun;

  modport master (
    output in_amp, in_ph, in_valid, clear, out_ready,
    input  out_amp, out_dph, out_ph, out_valid, overrun
  );

  modport slave (
    input  in_amp, in_ph, in_valid, clear, out_ready,
    output out_amp, out_dph, out_ph, out_valid, overrun
  );
endinterface

// File: rtl/amp_ph_freq_averager.sv
// Block averager behind the CORDIC detector: mean amplitude and mean phase increment
// (frequency) over 2^LOG2_LEN samples, presented on a one-entry valid/ready register.
module amp_ph_freq_averager #(
  parameter int FULL_SIZE = 20,
  parameter int LOG2_LEN  = 4
) (
  input logic                  clk,
  input logic                  reset,
  amp_ph_freq_averager_if.slave bus
);
  localparam int ACC_W = FULL_SIZE + LOG2_LEN;

  typedef enum logic {PRIME, ACCUM} state_t;

  state_t                      state_q, state_d;
  logic signed [FULL_SIZE-1:0] prev_ph;
  logic        [ACC_W-1:0]     amp_acc;
  logic signed [ACC_W-1:0]     dph_acc;
  logic        [LOG2_LEN-1:0]  cnt;

  logic                        prime_en;
  logic                        accum_en;
  logic                        blk_done;
  logic                        load;
  logic                        drop;
  logic signed [FULL_SIZE-1:0] dph;
  logic        [ACC_W-1:0]     amp_sum;
  logic signed [ACC_W-1:0]     dph_sum;

  function automatic logic [FULL_SIZE-1:0] mean_amp(input logic [ACC_W-1:0] s);
    return FULL_SIZE'(s >> LOG2_LEN);
  endfunction

  // Arithmetic shift floors toward -inf; no rounding term is added on purpose.
  function automatic logic signed [FULL_SIZE-1:0] mean_dph(input logic signed [ACC_W-1:0] s);
    return FULL_SIZE'(s >>> LOG2_LEN);
  endfunction

  // Modulo-2^FULL_SIZE difference makes the +/-pi crossing come out right for free.
  assign dph     = bus.in_ph - prev_ph;
  assign amp_sum = amp_acc + ACC_W'(bus.in_amp);
  assign dph_sum = dph_acc + {{LOG2_LEN{dph[FULL_SIZE-1]}}, dph};

  always_comb begin
    state_d  = state_q;
    prime_en = 1'b0;
    accum_en = 1'b0;
    blk_done = 1'b0;
    if (bus.clear) begin
      state_d = PRIME;
    end else if (bus.in_valid) begin
      case (state_q)
        PRIME: begin
          prime_en = 1'b1;
          state_d  = ACCUM;
        end
        ACCUM: begin
          accum_en = 1'b1;
          blk_done = (cnt == '1);
        end
        default: state_d = PRIME;
      endcase
    end
  end

  assign load = blk_done && (!bus.out_valid || bus.out_ready);
  assign drop = blk_done && !load;

  // Accumulation stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= PRIME;
      prev_ph <= '0;
      amp_acc <= '0;
      dph_acc <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (bus.clear) begin
        amp_acc <= '0;
        dph_acc <= '0;
        cnt     <= '0;
      end else if (prime_en) begin
        prev_ph <= bus.in_ph;
      end else if (accum_en) begin
        prev_ph <= bus.in_ph;
        if (blk_done) begin
          amp_acc <= '0;
          dph_acc <= '0;
          cnt     <= '0;
        end else begin
          amp_acc <= amp_sum;
          dph_acc <= dph_sum;
          cnt     <= cnt + 1'b1;
        end
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.out_amp   <= '0;
      bus.out_dph   <= '0;
      bus.out_ph    <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (load) begin
        bus.out_amp   <= mean_amp(amp_sum);
        bus.out_dph   <= mean_dph(dph_sum);
        bus.out_ph    <= bus.in_ph;
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (drop) begin
        bus.overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_amp_ph_freq_averager.sv
// Bench for amp_ph_freq_averager: two instances (block lengths 4 and 2) share stimulus
// and are compared against a sample-list arithmetic model of block means.
module tb_amp_ph_freq_averager;
  localparam int FS = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  amp_ph_freq_averager_if #(.FULL_SIZE(FS)) b2 ();
  amp_ph_freq_averager_if #(.FULL_SIZE(FS)) b1 ();

  amp_ph_freq_averager #(.FULL_SIZE(FS), .LOG2_LEN(2)) u2 (.clk(clk), .reset(rst_n), .bus(b2));
  amp_ph_freq_averager #(.FULL_SIZE(FS), .LOG2_LEN(1)) u1 (.clk(clk), .reset(rst_n), .bus(b1));

  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = block of 4, index 1 = block of 2.
  bit     primed [2];
  longint prev   [2];
  longint sa     [2];
  longint sd     [2];
  int     n      [2];
  bit     mv     [2];
  bit     mo     [2];
  longint ma     [2];
  longint md     [2];
  longint mp     [2];

  function automatic longint wrap20(input longint x);
    longint y;
    y = x;
    while (y >= 524288) y -= 1048576;
    while (y < -524288) y += 1048576;
    return y;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q -= 1;
    return q;
  endfunction

  function automatic void model(input int i, input bit v, input longint amp, input longint ph,
                                input bit clr, input bit rdy);
    longint nlen;
    bit     res;
    longint ra, rd;
    nlen = (i == 0) ? 4 : 2;
    res = 0; ra = 0; rd = 0;
    if (!rst_n) begin
      primed[i] = 0; prev[i] = 0; sa[i] = 0; sd[i] = 0; n[i] = 0;
      mv[i] = 0; mo[i] = 0; ma[i] = 0; md[i] = 0; mp[i] = 0;
      return;
    end
    if (clr) begin
      primed[i] = 0; sa[i] = 0; sd[i] = 0; n[i] = 0;
    end else if (v) begin
      if (!primed[i]) begin
        primed[i] = 1;
        prev[i] = ph;
      end else begin
        sd[i] += wrap20(ph - prev[i]);
        sa[i] += amp;
        prev[i] = ph;
        n[i]++;
        if (n[i] == nlen) begin
          res = 1;
          ra = sa[i] / nlen;
          rd = floor_div(sd[i], nlen);
          sa[i] = 0; sd[i] = 0; n[i] = 0;
        end
      end
    end
    if (res) begin
      if (!mv[i] || rdy) begin
        mv[i] = 1; ma[i] = ra; md[i] = rd; mp[i] = ph;
      end else begin
        mo[i] = 1;
      end
    end else if (mv[i] && rdy) begin
      mv[i] = 0;
    end
  endfunction

  function automatic logic [62:0] mdl_out(input int i);
    return {mv[i], mo[i], ma[i][19:0], md[i][19:0], mp[i][19:0]};
  endfunction

  function automatic logic [62:0] dut_out(input int i);
    if (i == 0) return {b2.out_valid, b2.overrun, b2.out_amp, b2.out_dph, b2.out_ph};
    return {b1.out_valid, b1.overrun, b1.out_amp, b1.out_dph, b1.out_ph};
  endfunction

  task automatic step(input bit v, input longint amp, input longint ph, input bit clr, input bit rdy);
    @(negedge clk);
    b2.in_valid = v;  b2.in_amp = amp[19:0]; b2.in_ph = ph[19:0]; b2.clear = clr; b2.out_ready = rdy;
    b1.in_valid = v;  b1.in_amp = amp[19:0]; b1.in_ph = ph[19:0]; b1.clear = clr; b1.out_ready = rdy;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model(i, v, amp, ph, clr, rdy);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step(1, 55, 1234, 0, 1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_out(i) !== 63'd0) begin
          errors++;
          $display("FAIL reset dut%0d got %h want 0", i, dut_out(i));
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1, 1000, k * 100, 0, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_out(i) !== mdl_out(i)) begin
          errors++;
          $display("FAIL ramp dut%0d sample %0d got %h want %h", i, k, dut_out(i), mdl_out(i));
        end
      end
      if (k == 3) begin
        checks++;
        if (b2.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL ramp_early_valid got %b want 0", b2.out_valid);
        end
      end
    end
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_amp !== 20'd1000 || b2.out_dph !== 20'sd100 || b2.out_ph !== 20'sd400) begin
      errors++;
      $display("FAIL ramp_result got v=%b amp=%0d dph=%0d ph=%0d want v=1 amp=1000 dph=100 ph=400",
               b2.out_valid, b2.out_amp, b2.out_dph, b2.out_ph);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (b2.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ramp_drain got valid=%b want 0", b2.out_valid);
    end
  endtask

  task automatic test_wrap();
    longint ph [5] = '{524100, 524200, -524276, -524176, -524076};
    do_reset();
    foreach (ph[k]) step(1, 7, ph[k], 0, 0);
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_dph !== 20'sd100 || b2.out_ph !== -20'sd524076) begin
      errors++;
      $display("FAIL wrap got v=%b dph=%0d ph=%0d want v=1 dph=100 ph=-524076",
               b2.out_valid, b2.out_dph, b2.out_ph);
    end
  endtask

  task automatic test_neg_floor();
    longint ph  [5] = '{0, -1, -3, -4, -6};
    longint amp [5] = '{9, 1, 2, 2, 2};
    do_reset();
    foreach (ph[k]) step(1, amp[k], ph[k], 0, 0);
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_dph !== -20'sd2 || b2.out_amp !== 20'd1) begin
      errors++;
      $display("FAIL neg_floor got v=%b dph=%0d amp=%0d want v=1 dph=-2 amp=1",
               b2.out_valid, b2.out_dph, b2.out_amp);
    end
  endtask

  task automatic test_overrun();
    longint ph;
    do_reset();
    ph = 0;
    for (int k = 0; k < 9; k++) begin
      ph = wrap20(ph + longint'($urandom_range(0, 60000)) - 30000);
      step(1, longint'($urandom_range(0, 1048575)), ph, 0, 0);
      checks++;
      if (dut_out(0) !== mdl_out(0)) begin
        errors++;
        $display("FAIL overrun_seq sample %0d got %h want %h", k, dut_out(0), mdl_out(0));
      end
    end
    checks++;
    if (b2.overrun !== 1'b1 || b2.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag got ovr=%b v=%b want ovr=1 v=1", b2.overrun, b2.out_valid);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (b2.out_valid !== 1'b0 || b2.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drain got v=%b ovr=%b want v=0 ovr=1", b2.out_valid, b2.overrun);
    end
  endtask

  task automatic test_back_to_back();
    longint ph;
    do_reset();
    ph = 1000;
    for (int k = 0; k < 20; k++) begin
      ph = wrap20(ph + longint'($urandom_range(0, 200000)) - 100000);
      step(1, longint'($urandom_range(0, 1048575)), ph, 0, 1);
      checks++;
      if (b1.out_valid !== ((k >= 2) && (k % 2 == 0)) || b1.overrun !== 1'b0) begin
        errors++;
        $display("FAIL b2b_pulse sample %0d got v=%b ovr=%b want v=%b ovr=0",
                 k, b1.out_valid, b1.overrun, (k >= 2) && (k % 2 == 0));
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_out(i) !== mdl_out(i)) begin
          errors++;
          $display("FAIL b2b dut%0d sample %0d got %h want %h", i, k, dut_out(i), mdl_out(i));
        end
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 50000, k * 3000, 0, 0);
    step(1, 99999, 200000, 1, 0);
    for (int k = 0; k < 5; k++) step(1, 100 + k * 10, -5000 * k, 0, 0);
    checks++;
    if (b2.out_valid !== 1'b1 || b2.out_amp !== 20'd125 || b2.out_dph !== -20'sd5000 || b2.out_ph !== -20'sd20000) begin
      errors++;
      $display("FAIL clear_result got v=%b amp=%0d dph=%0d ph=%0d want v=1 amp=125 dph=-5000 ph=-20000",
               b2.out_valid, b2.out_amp, b2.out_dph, b2.out_ph);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_out(i) !== mdl_out(i)) begin
        errors++;
        $display("FAIL clear dut%0d got %h want %h", i, dut_out(i), mdl_out(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 7; k++) step(1, 3000, k * 700, 0, 0);
    rst_n = 1'b0;
    step(1, 3000, 4900, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_out(i) !== 63'd0) begin
        errors++;
        $display("FAIL reset_mid dut%0d got %h want 0", i, dut_out(i));
      end
    end
    for (int k = 0; k < 5; k++) step(1, 40 + k, 90000 + 17 * k, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_out(i) !== mdl_out(i)) begin
        errors++;
        $display("FAIL reset_mid_after dut%0d got %h want %h", i, dut_out(i), mdl_out(i));
      end
    end
  endtask

  task automatic test_random();
    longint ph;
    bit     v, clr, rdy;
    do_reset();
    ph = 0;
    for (int k = 0; k < 400; k++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) ph = longint'($urandom_range(0, 1048575)) - 524288;
      else ph = wrap20(ph + longint'($urandom_range(0, 40000)) - 20000);
      step(v, longint'($urandom_range(0, 1048575)), ph, clr, rdy);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_out(i) !== mdl_out(i)) begin
          errors++;
          $display("FAIL random dut%0d cycle %0d got %h want %h", i, k, dut_out(i), mdl_out(i));
        end
      end
    end
  endtask

  initial begin
    b2.in_valid = 0; b2.in_amp = 0; b2.in_ph = 0; b2.clear = 0; b2.out_ready = 0;
    b1.in_valid = 0; b1.in_amp = 0; b1.in_ph = 0; b1.clear = 0; b1.out_ready = 0;
    b2.in_amp_unused_guard = 0;
    b1.in_amp_unused_guard = 0;
    test_reset();
    test_ramp();
    test_wrap();
    test_neg_floor();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/amp_ph_freq_averager.md
# amp_ph_freq_averager

Post-processing stage fed directly by the CORDIC amplitude/phase detector. It takes the detector's amplitude, phase and valid outputs and forms block averages over 2^LOG2_LEN samples: mean amplitude, and mean phase increment per sample (the frequency estimate), computed with modulo phase differencing. Each result carries the last phase of its block and is presented on a one-entry valid/ready output register with a sticky overrun flag.

## Interface
- FULL_SIZE, 20, width of the amplitude and phase inputs and outputs. Matches the detector output width.
- LOG2_LEN, 4, log2 of the block length; valid range 1..8.
- clk  input  1  clock
- reset  input  1  synchronous reset, active-low
- in_amp  input  FULL_SIZE  detector amplitude, unsigned, CORDIC gain included
- in_ph  input  FULL_SIZE  detector phase, signed two's complement; -2^(FULL_SIZE-1) = -pi, full circle = 2^FULL_SIZE
- in_valid  input  1  sample strobe; there is no upstream backpressure
- clear  input  1  synchronous restart of accumulation; the output register is unaffected
- out_amp  output  FULL_SIZE  block mean amplitude, unsigned
- out_dph  output  FULL_SIZE  block mean phase increment, signed
- out_ph  output  FULL_SIZE  phase of the last sample in the block
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- overrun  output  1  sticky; a result was dropped

## Operation
- All outputs and internal state are 0 while reset is low. After reset the state is PRIME.
- States: PRIME and ACCUM.
- PRIME:
  - An in_valid sample loads prev_ph <= in_ph and is not counted.
  - The next state is ACCUM.
- ACCUM, per in_valid sample:
  - dph = in_ph - prev_ph, taken modulo 2^FULL_SIZE and interpreted as signed. Wrap-around across ±pi needs no special handling.
  - prev_ph <= in_ph.
  - amp_acc (unsigned, FULL_SIZE+LOG2_LEN bits) += in_amp.
  - dph_acc (signed, FULL_SIZE+LOG2_LEN bits) += sign-extended dph.
  - cnt (LOG2_LEN bits) increments.
- Block completion, on the sample where cnt = 2^LOG2_LEN-1:
  - result_amp = (amp_acc+in_amp) >> LOG2_LEN, logical shift.
  - result_dph = (dph_acc+dph) >>> LOG2_LEN, arithmetic shift (floor; no rounding).
  - result_ph = in_ph.
  - amp_acc, dph_acc and cnt clear to 0. The state stays ACCUM, and prev_ph continuity is kept, so the next block starts without re-priming.
- Output register:
  - A result loads out_amp, out_dph and out_ph, and sets out_valid=1, if out_valid=0 or out_ready=1 in the same cycle.
  - Otherwise the result is dropped, the held output is unchanged, and overrun is set to 1.
  - A transfer occurs when out_valid & out_ready. With no new result in that cycle, out_valid goes to 0 and the data registers hold their values.
  - A transfer and a new result in the same cycle load the new result, keep out_valid=1, and do not set overrun.
  - overrun clears only on reset.
- clear=1:
  - amp_acc, dph_acc and cnt clear to 0 and the state goes to PRIME.
  - A sample with in_valid in the same cycle is ignored.
  - clear has priority over block completion.
  - The output register, out_valid and overrun are unaffected.
- Reset low mid-block discards the partial block and any held result. The block restarts in PRIME.

## Timing
- Accumulator and output updates occur on the clk edge that samples in_valid.
- The completing sample at edge t gives out_valid=1 and new data visible after edge t. Latency is 1 cycle.
- The first result after reset or clear needs 2^LOG2_LEN+1 samples. Later results need 2^LOG2_LEN samples each.
- Throughput is one sample per cycle. in_valid gaps of any length do not affect the results.
- The output data is stable while out_valid=1 and out_ready=0, except through a legal simultaneous load.

## Test plan
- LOG2_LEN=2. Drive in_amp=1000 constant and in_ph=0,100,…,400 with in_valid every cycle.
  - One result: out_amp=1000, out_dph=100, out_ph=400.
  - out_valid rises the cycle after the 5th sample.
- Phase wrap.
  - Stimulus: LOG2_LEN=2, in_ph=524100, 524200, 524300-2^20 (= -524276), -524176, -524076.
  - Required: out_dph=100, out_ph=-524076.
- Negative floor.
  - Stimulus: LOG2_LEN=2, increments -1, -2, -1, -2 (sum -6).
  - Required: out_dph=-2.
  - Also: in_amp=1,2,2,2 must give out_amp=1 (truncation).
- Overrun.
  - Stimulus: LOG2_LEN=2, out_ready=0, 9 samples.
  - Required: the first result is held, overrun=1 after sample 9, and the second result is lost.
  - After that, out_ready=1 for one cycle must give out_valid=0 and overrun still 1.
- Back-to-back.
  - Stimulus: LOG2_LEN=1, out_ready=1 constant, continuous in_valid.
  - Required: out_valid pulses every 2nd cycle after priming, with overrun=0 throughout.
- Clear and reset mid-block.
  - Clear after 2 of 4 samples, then 5 more samples must give a result from only the post-clear samples.
  - Reset low for one cycle mid-block must give all outputs 0 and restart in PRIME.
